control_pipeline: RTL
=====================

# control_pipeline

Parametrised control-word pipeline for the MIPS PPU. It carries decoded control fields from ID through EX, MEM and WB stage registers. It detects load-use hazards and inserts bubbles for them. It also honours external stall and ID-flush requests. This block supersedes the single-stage CMUX zeroing multiplexer: bubble insertion, hazard detection and stage registering all live here, between the control unit and the datapath stage logic.

## Interface
- EX_W, 6: width of EX-stage control field (ALUOp, S0_S2, …)
- MEM_W, 6: width of MEM-stage control field (Data_Mem RW/Enable/Size/SE, MEM_MUX)
- WB_W, 5: width of WB-stage control field (Load, MemtoReg, LoEnable, RegFileEnable, HiEnable)
- CNT_W, 16: width of bubble counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_ctrl_ex / id_ctrl_mem / id_ctrl_wb  in  EX_W / MEM_W / WB_W  decoded control fields
- id_dest  in  5  destination register number (0 = none)
- id_is_load  in  1  instruction is a load
- id_rs, id_rt  in  5 each  source register numbers
- id_uses_rs, id_uses_rt  in  1 each  source actually read
- ext_stall  in  1  freeze entire pipe (memory not ready)
- flush_id  in  1  kill the instruction currently in ID (taken branch/jump)
- hazard_stall  out  1  combinational; IF/ID must hold PC and IF/ID register
- ex_valid, ex_ctrl_ex, ex_ctrl_mem, ex_ctrl_wb, ex_dest, ex_is_load  out  EX stage registers
- mem_valid, mem_ctrl_mem, mem_ctrl_wb, mem_dest  out  MEM stage registers
- wb_valid, wb_ctrl_wb, wb_dest  out  WB stage registers
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Bubble: valid=0, all ctrl bits 0, dest=0, is_load=0. A bubble performs no write and no memory access.
- hazard = id_valid & ex_valid & ex_is_load & (ex_dest≠0) & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest)).
- hazard_stall = hazard & ~flush_id. A flushed instruction never needs to be held.
- Per-edge update priority:
  - ext_stall=1: every stage register holds; bubble_count holds. ext_stall overrides flush and hazard.
  - else flush_id=1 or hazard=1: EX loads a bubble; MEM←EX; WB←MEM.
  - else: EX←ID fields (valid=id_valid; if id_valid=0, ctrl fields are loaded as zeros); MEM←EX; WB←MEM.
- MEM carries only the mem/wb fields of EX. WB carries only the wb field of MEM.
- bubble_count increments by 1 on an edge with ~ext_stall & id_valid & (flush_id | hazard). It saturates at 2^CNT_W−1 and never wraps.
- A load whose dest is r0 never raises a hazard.
- A load followed by a dependent instruction causes exactly one bubble. On the next cycle the load is in MEM and EX holds the bubble, so hazard deasserts.

## Timing
- Reset: all valid bits, ctrl fields, dest, ex_is_load and bubble_count are 0. hazard_stall is 0 because ex_valid=0.
- Reset takes effect immediately, including mid-stall or mid-hazard. The first edge after deassertion performs a normal update.
- Latency: ID fields appear on ex_* 1 edge later, mem_* 2 edges later and wb_* 3 edges later, absent stalls.
- hazard_stall is valid in the same cycle as the ID inputs, with no registered delay.
- ext_stall held N cycles delays all stages by exactly N edges, with no loss or duplication.
- flush_id together with hazard in the same cycle counts as one bubble.

## Test plan
- Reset then stream: apply id_valid=1, id_ctrl_ex=6'h15, id_dest=8, then idle. Require ex_ctrl_ex=6'h15 after edge 1, mem_dest=8 after edge 2, wb_dest=8 and wb_valid=1 after edge 3.
- Load-use: LW to dest=5 followed by an instruction with id_rs=5, id_uses_rs=1. Require hazard_stall=1 for exactly one cycle, a bubble in EX (ex_valid=0), the dependent instruction entering EX one edge later, and bubble_count=1. Repeat with dest=0 or id_uses_rs=0: require hazard_stall=0.
- Flush: send instruction A, then B with flush_id=1. Require B never to appear with valid=1 in EX/MEM/WB while A proceeds normally. Assert flush and hazard together: require bubble_count to increase by 1 and hazard_stall=0.
- ext_stall: with 3 valid instructions in flight, hold ext_stall for 4 cycles. Require all stage outputs and bubble_count unchanged, then resumed progress in order. Check that ext_stall asserted during a hazard inserts no bubble until it is released.
- Saturation: with CNT_W=3, force 10 hazards. Require bubble_count=7 and held there.
- Async reset mid-pipe: assert reset between edges with all stages valid. Require all outputs to be 0 before the next edge.

Source files
------------

// File: rtl/control_pipeline.sv
// control_pipeline: ID->EX->MEM->WB control-word pipeline with load-use bubble insertion
module control_pipeline #(
    parameter int EX_W  = 6,
    parameter int MEM_W = 6,
    parameter int WB_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [EX_W-1:0]  id_ctrl_ex,
    input  logic [MEM_W-1:0] id_ctrl_mem,
    input  logic [WB_W-1:0]  id_ctrl_wb,
    input  logic [4:0]       id_dest,
    input  logic             id_is_load,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ext_stall,
    input  logic             flush_id,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic [EX_W-1:0]  ex_ctrl_ex,
    output logic [MEM_W-1:0] ex_ctrl_mem,
    output logic [WB_W-1:0]  ex_ctrl_wb,
    output logic [4:0]       ex_dest,
    output logic             ex_is_load,
    output logic             mem_valid,
    output logic [MEM_W-1:0] mem_ctrl_mem,
    output logic [WB_W-1:0]  mem_ctrl_wb,
    output logic [4:0]       mem_dest,
    output logic             wb_valid,
    output logic [WB_W-1:0]  wb_ctrl_wb,
    output logic [4:0]       wb_dest,
    output logic [CNT_W-1:0] bubble_count
);

    logic hazard;
    logic bubble;
    logic take;

    // Load-use detection against the load sitting in EX; a flushed ID slot never needs holding
    always_comb begin
        hazard       = id_valid & ex_valid & ex_is_load & (ex_dest != 5'd0) &
                       ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));
        bubble       = hazard | flush_id;
        take         = id_valid & ~bubble;
        hazard_stall = hazard & ~flush_id;
    end

    // Stage registers: freeze on ext_stall, otherwise shift with a bubble injected into EX when needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_ctrl_ex   <= '0;
            ex_ctrl_mem  <= '0;
            ex_ctrl_wb   <= '0;
            ex_dest      <= '0;
            ex_is_load   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_ctrl_mem <= '0;
            mem_ctrl_wb  <= '0;
            mem_dest     <= '0;
            wb_valid     <= 1'b0;
            wb_ctrl_wb   <= '0;
            wb_dest      <= '0;
        end else if (!ext_stall) begin
            ex_valid     <= take;
            ex_ctrl_ex   <= take ? id_ctrl_ex : '0;
            ex_ctrl_mem  <= take ? id_ctrl_mem : '0;
            ex_ctrl_wb   <= take ? id_ctrl_wb : '0;
            ex_dest      <= take ? id_dest : '0;
            ex_is_load   <= take & id_is_load;
            mem_valid    <= ex_valid;
            mem_ctrl_mem <= ex_ctrl_mem;
            mem_ctrl_wb  <= ex_ctrl_wb;
            mem_dest     <= ex_dest;
            wb_valid     <= mem_valid;
            wb_ctrl_wb   <= mem_ctrl_wb;
            wb_dest      <= mem_dest;
        end
    end

    // Saturating count of real instructions turned into bubbles (flush and hazard together count once)
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_count <= '0;
        else if (!ext_stall && id_valid && bubble && !(&bubble_count))
            bubble_count <= bubble_count + CNT_W'(1);
    end

endmodule
